// File: rtl/dcache_fill_pkg.sv
// Shared types and helpers for the data-cache line-fill engine.
package dcache_fill_pkg;

    localparam int LGLINE_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_FILL   = 2'b10
    } state_t;

    // Clear the low lgline bits of a word address to get its line base.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned lgline);
        logic [63:0] mask;
        mask = ~((64'd1 << lgline) - 64'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/dcache_fill_if.sv
// Request/response and Wishbone bundle of the fill engine.
interface dcache_fill_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    import dcache_fill_pkg::*;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_cachable;
    logic          o_busy;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_err;
    logic          o_fill_we;
    logic [AW-1:0] o_fill_addr;
    logic [DW-1:0] o_fill_data;
    logic          o_line_done;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic [AW-1:0] o_wb_addr;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic [DW-1:0] i_wb_data;

    modport master (
        input  i_req, i_addr, i_cachable, i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_busy, o_valid, o_data, o_err, o_fill_we, o_fill_addr, o_fill_data,
               o_line_done, o_wb_cyc, o_wb_stb, o_wb_addr
    );

    modport slave (
        output i_req, i_addr, i_cachable, i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_busy, o_valid, o_data, o_err, o_fill_we, o_fill_addr, o_fill_data,
               o_line_done, o_wb_cyc, o_wb_stb, o_wb_addr
    );

endinterface

// File: rtl/dcache_fill_wb_beat_counter.sv
// Counts accepted Wishbone beats and acks of one burst. The flags fire in the
// cycle the final beat is accepted / the final ack arrives, so the owner can
// drop stb or cyc on that same edge.
module wb_beat_counter #(
    parameter int LG = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clr,
    input  logic        i_req_acc,
    input  logic        i_ack,
    output logic [LG:0] o_ack_cnt,
    output logic        o_all_issued,
    output logic        o_all_acked
);
    localparam logic [LG:0] LAST = {1'b0, {LG{1'b1}}};
    localparam logic [LG:0] ONE  = {{LG{1'b0}}, 1'b1};

    logic [LG:0] req_cnt;

    // Request and ack counters, cleared between bursts.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_cnt   <= '0;
            o_ack_cnt <= '0;
        end else if (i_clr) begin
            req_cnt   <= '0;
            o_ack_cnt <= '0;
        end else begin
            if (i_req_acc) req_cnt   <= req_cnt + ONE;
            if (i_ack)     o_ack_cnt <= o_ack_cnt + ONE;
        end
    end

    assign o_all_issued = i_req_acc && (req_cnt == LAST);
    assign o_all_acked  = i_ack && (o_ack_cnt == LAST);

endmodule

// File: rtl/dcache_fill.sv
// Line-fill / uncached-read engine: one miss at a time, burst fill for
// cachable lines, single-beat read otherwise. All outputs are registered.
module dcache_fill
    import dcache_fill_pkg::*;
#(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int LGLINE = LGLINE_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    dcache_fill_if.master  bus
);
    localparam logic [LGLINE-1:0] OFF_ONE = {{(LGLINE-1){1'b0}}, 1'b1};

    state_t            state, state_n;
    logic              cyc, cyc_n, stb, stb_n;
    logic [AW-1:0]     wb_addr, wb_addr_n;
    logic [LGLINE-1:0] off, off_n;
    logic              valid, valid_n, err, err_n, we, we_n, done, done_n;
    logic [DW-1:0]     data, data_n, fdata, fdata_n;
    logic [AW-1:0]     faddr, faddr_n;

    logic              acc, ack_g, err_g;
    logic [LGLINE:0]   ack_cnt;
    logic              all_issued, all_acked;

    // Responses only count while we own the bus; err overrides a coincident ack.
    assign acc   = stb & ~bus.i_wb_stall;
    assign err_g = cyc & bus.i_wb_err;
    assign ack_g = cyc & bus.i_wb_ack & ~bus.i_wb_err;

    wb_beat_counter #(.LG(LGLINE)) u_cnt (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clr       (state == ST_IDLE),
        .i_req_acc   (acc),
        .i_ack       (ack_g),
        .o_ack_cnt   (ack_cnt),
        .o_all_issued(all_issued),
        .o_all_acked (all_acked)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        stb_n     = stb;
        wb_addr_n = wb_addr;
        off_n     = off;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        we_n      = 1'b0;
        done_n    = 1'b0;
        data_n    = data;
        fdata_n   = fdata;
        faddr_n   = faddr;
        case (state)
            ST_IDLE: begin
                if (bus.i_req) begin
                    cyc_n = 1'b1;
                    stb_n = 1'b1;
                    if (bus.i_cachable) begin
                        state_n   = ST_FILL;
                        wb_addr_n = AW'(line_base(64'(bus.i_addr), LGLINE));
                        off_n     = bus.i_addr[LGLINE-1:0];
                    end else begin
                        state_n   = ST_SINGLE;
                        wb_addr_n = bus.i_addr;
                    end
                end
            end
            ST_SINGLE: begin
                if (acc) stb_n = 1'b0;
                if (err_g) begin
                    cyc_n   = 1'b0;
                    stb_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else if (ack_g) begin
                    cyc_n   = 1'b0;
                    stb_n   = 1'b0;
                    data_n  = bus.i_wb_data;
                    valid_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_FILL: begin
                // Offset wraps inside the line; the line base never changes.
                if (acc) begin
                    wb_addr_n = {wb_addr[AW-1:LGLINE], wb_addr[LGLINE-1:0] + OFF_ONE};
                    if (all_issued) stb_n = 1'b0;
                end
                if (err_g) begin
                    cyc_n   = 1'b0;
                    stb_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else if (ack_g) begin
                    we_n    = 1'b1;
                    fdata_n = bus.i_wb_data;
                    faddr_n = {wb_addr[AW-1:LGLINE], ack_cnt[LGLINE-1:0]};
                    if (ack_cnt == {1'b0, off}) data_n = bus.i_wb_data;
                    if (all_acked) begin
                        cyc_n   = 1'b0;
                        stb_n   = 1'b0;
                        valid_n = 1'b1;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            wb_addr <= '0;
            off     <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            we      <= 1'b0;
            done    <= 1'b0;
            data    <= '0;
            fdata   <= '0;
            faddr   <= '0;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            stb     <= stb_n;
            wb_addr <= wb_addr_n;
            off     <= off_n;
            valid   <= valid_n;
            err     <= err_n;
            we      <= we_n;
            done    <= done_n;
            data    <= data_n;
            fdata   <= fdata_n;
            faddr   <= faddr_n;
        end
    end

    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_valid     = valid;
    assign bus.o_data      = data;
    assign bus.o_err       = err;
    assign bus.o_fill_we   = we;
    assign bus.o_fill_addr = faddr;
    assign bus.o_fill_data = fdata;
    assign bus.o_line_done = done;
    assign bus.o_wb_cyc    = cyc;
    assign bus.o_wb_stb    = stb;
    assign bus.o_wb_addr   = wb_addr;

endmodule

// File: tb/tb_dcache_fill.sv
// Bench for dcache_fill: vector table driven through a Wishbone slave model,
// with scoreboard queues for bus addresses, fill writes and responses.
module tb_dcache_fill;
    localparam int LINE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    dcache_fill_if #(.AW(24), .DW(32)) bus();

    dcache_fill #(.AW(24), .DW(32), .LGLINE(3)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [23:0] addr;
        bit          cach;
        int          lat;
        int          stall_beat;
        int          stall_len;
        int          err_ack;
        bit          poke;
        int          exp_lat;
        int          exp_beats;
        int          exp_fills;
    } vec_t;

    typedef struct { logic [23:0] a; logic [31:0] d; } fill_t;
    typedef struct { logic [31:0] d; bit err; bit done; } rsp_t;
    typedef struct { int due; logic [23:0] a; } pend_t;

    vec_t        vecs[9];
    logic [23:0] exp_addr[$];
    fill_t       exp_fill[$];
    rsp_t        exp_rsp[$];
    pend_t       pend[$];

    int total = 0, bad = 0;
    int sl_lat = 1, stall_beat = 0, stall_left = 0, err_ack = 0;
    int beats_acc = 0, resp_cnt = 0, fills_seen = 0, rsp_seen = 0, rsp_cycle = 0;

    function automatic logic [31:0] mem(input logic [23:0] a);
        return (a == 24'h000100) ? 32'hDEADBEEF : {8'h00, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One negedge of monitor + Wishbone slave.
    task automatic bus_step();
        pend_t p;
        fill_t f;
        rsp_t  r;
        logic [23:0] ea;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_data  = '0;
        if (bus.o_fill_we) begin
            fills_seen++;
            if (exp_fill.size() == 0) chk("fill_extra", 64'(bus.o_fill_we), 64'(0));
            else begin
                f = exp_fill.pop_front();
                chk("fill_addr", 64'(bus.o_fill_addr), 64'(f.a));
                chk("fill_data", 64'(bus.o_fill_data), 64'(f.d));
            end
        end
        if (bus.o_valid || bus.o_err) begin
            rsp_seen++;
            rsp_cycle = cyc_cnt;
            if (exp_rsp.size() == 0) chk("rsp_extra", 64'({bus.o_valid, bus.o_err}), 64'(0));
            else begin
                r = exp_rsp.pop_front();
                chk("rsp_err", 64'(bus.o_err), 64'(r.err));
                chk("rsp_valid", 64'(bus.o_valid), 64'(!r.err));
                chk("line_done", 64'(bus.o_line_done), 64'(r.done));
                chk("busy_at_rsp", 64'(bus.o_busy), 64'(0));
                if (!r.err) chk("rsp_data", 64'(bus.o_data), 64'(r.d));
            end
        end else if (bus.o_line_done) chk("stray_line_done", 64'(bus.o_line_done), 64'(0));
        if (bus.o_wb_cyc && rst_n) begin
            if (bus.o_wb_stb && beats_acc == stall_beat && stall_left > 0) begin
                bus.i_wb_stall = 1'b1;
                stall_left--;
            end
            if (bus.o_wb_stb && !bus.i_wb_stall) begin
                beats_acc++;
                if (exp_addr.size() == 0) chk("bus_extra", 64'(bus.o_wb_stb), 64'(0));
                else begin
                    ea = exp_addr.pop_front();
                    chk("bus_addr", 64'(bus.o_wb_addr), 64'(ea));
                end
                p.due = cyc_cnt + sl_lat;
                p.a   = bus.o_wb_addr;
                pend.push_back(p);
            end
            if (pend.size() != 0 && pend[0].due == cyc_cnt) begin
                p = pend.pop_front();
                resp_cnt++;
                if (resp_cnt == err_ack) bus.i_wb_err = 1'b1;
                else begin
                    bus.i_wb_ack  = 1'b1;
                    bus.i_wb_data = mem(p.a);
                end
            end
        end else pend.delete();
    endtask

    initial begin
        bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; bus.i_wb_stall = 1'b0; bus.i_wb_data = '0;
        forever begin
            @(negedge clk);
            bus_step();
        end
    end

    task automatic load_exp(input vec_t v);
        logic [23:0] base;
        fill_t f;
        rsp_t  r;
        int    nfill;
        sl_lat = v.lat; stall_beat = v.stall_beat; stall_left = v.stall_len; err_ack = v.err_ack;
        beats_acc = 0; resp_cnt = 0; fills_seen = 0;
        exp_addr.delete(); exp_fill.delete(); exp_rsp.delete();
        base = v.cach ? {v.addr[23:3], 3'b000} : v.addr;
        if (v.cach) for (int i = 0; i < LINE; i++) exp_addr.push_back({base[23:3], 3'(i)});
        else exp_addr.push_back(v.addr);
        nfill = !v.cach ? 0 : (v.err_ack != 0 ? v.err_ack - 1 : LINE);
        for (int i = 0; i < nfill; i++) begin
            f.a = {base[23:3], 3'(i)};
            f.d = mem(f.a);
            exp_fill.push_back(f);
        end
        r.d = mem(v.addr); r.err = (v.err_ack != 0); r.done = v.cach && (v.err_ack == 0);
        exp_rsp.push_back(r);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int t0, rs;
        load_exp(v);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = v.addr; bus.i_cachable = v.cach;
        t0 = cyc_cnt; rs = rsp_seen;
        @(negedge clk);
        if (v.poke) begin
            // A second request while busy must be ignored.
            bus.i_addr = 24'h000300; bus.i_cachable = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
        bus.i_req = 1'b0;
        for (int n = 0; n < 200 && rsp_seen == rs; n++) @(negedge clk);
        chk({tag, "_timeout"}, 64'(rsp_seen), 64'(rs + 1));
        repeat (3) @(negedge clk);
        chk({tag, "_latency"}, 64'(rsp_cycle - t0), 64'(v.exp_lat));
        chk({tag, "_beats"}, 64'(beats_acc), 64'(v.exp_beats));
        chk({tag, "_fills"}, 64'(fills_seen), 64'(v.exp_fills));
        chk({tag, "_rsp_count"}, 64'(rsp_seen), 64'(rs + 1));
    endtask

    initial begin
        vec_t v;
        int   rs;
        //          addr        c  lat sb sl err pk lat beats fills
        vecs[0] = '{24'h000100, 0, 2,  0, 0, 0,  0, 4,  1,    0};
        vecs[1] = '{24'h800013, 1, 1,  0, 0, 0,  0, 10, 8,    8};
        vecs[2] = '{24'h800013, 1, 1,  3, 3, 0,  0, 13, 8,    8};
        vecs[3] = '{24'h800013, 1, 1,  0, 0, 5,  0, 7,  6,    4};
        vecs[4] = '{24'h000027, 1, 2,  0, 0, 0,  0, 11, 8,    8};
        vecs[5] = '{24'h0000F8, 1, 1,  0, 0, 0,  0, 10, 8,    8};
        vecs[6] = '{24'h000200, 0, 1,  0, 0, 1,  0, 3,  1,    0};
        vecs[7] = '{24'hFFFFFD, 1, 1,  0, 0, 0,  0, 10, 8,    8};
        vecs[8] = '{24'h000180, 0, 2,  0, 0, 0,  1, 4,  1,    0};

        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_cachable = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 64'({bus.o_busy, bus.o_valid, bus.o_err, bus.o_fill_we,
                              bus.o_line_done, bus.o_wb_cyc, bus.o_wb_stb}), 64'(0));
        chk("rst_wb_addr", 64'(bus.o_wb_addr), 64'(0));
        chk("rst_data", 64'(bus.o_data), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while the third beat of a fill is on the bus.
        v = '{24'h800013, 1, 1, 0, 0, 0, 0, 10, 8, 8};
        load_exp(v);
        exp_rsp.delete();
        rs = rsp_seen;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = v.addr; bus.i_cachable = 1'b1;
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_flags", 64'({bus.o_busy, bus.o_valid, bus.o_err, bus.o_fill_we,
                                 bus.o_line_done, bus.o_wb_cyc, bus.o_wb_stb}), 64'(0));
        chk("rstmid_wb_addr", 64'(bus.o_wb_addr), 64'(0));
        chk("rstmid_fill_addr", 64'(bus.o_fill_addr), 64'(0));
        chk("rstmid_fill_data", 64'(bus.o_fill_data), 64'(0));
        chk("rstmid_data", 64'(bus.o_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_no_rsp", 64'(rsp_seen), 64'(rs));
        v = '{24'h840000, 1, 1, 0, 0, 0, 0, 10, 8, 8};
        run_vec(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
